y_diff_checker: RTL and testbench
=================================

# y_diff_checker

Downstream consumer of the fuzz-harness DUT output bus `y`. It samples two copies of `y` on every `clk` edge where the sample strobe is high: `y_a` from the synthesized netlist and `y_b` from the behavioural reference. It compresses each stream into a 32-bit MISR signature, counts mismatching samples and records the index of the first divergence. It replaces per-cycle `$strobe` dumps with a compact, self-checking pass/fail result per stimulus run.

## Interface
- `WIDTH`, 246, width of each `y` bus.
- `NSAMP`, 22, samples per run (1..255).
- `POLY`, 32'h04C11DB7, MISR feedback polynomial.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE or DONE only.
- `valid`  in  1  `y_a`/`y_b` hold a sample this cycle.
- `y_a`  in  WIDTH  netlist output.
- `y_b`  in  WIDTH  reference output.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE, held until the next `start` or `rst`.
- `mismatch`  out  1  sticky; at least one sample in this run had `y_a != y_b`.
- `mism_count`  out  8  mismatching samples in this run; saturates at 255.
- `first_idx`  out  8  zero-based index of the first mismatching sample; meaningful only when `mismatch` = 1.
- `samp_idx`  out  8  samples accepted so far in this run.
- `sig_a`  out  32  MISR signature of `y_a`.
- `sig_b`  out  32  MISR signature of `y_b`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- `rst` (synchronous, active-high):
  - moves the FSM to IDLE;
  - clears every output to 0, including `sig_a` and `sig_b`;
  - overrides all other inputs in the same cycle.
- IDLE: when `start` = 1, go to RUN. The same edge sets `sig_a` and `sig_b` to 32'hFFFFFFFF and clears `samp_idx`, `mism_count`, `first_idx` and `mismatch`.
- RUN: `start` is ignored. On each edge with `valid` = 1:
  - Fold: form `f` as the XOR of the 32-bit chunks of `y`. `y` is zero-extended to a multiple of 32 bits, giving 8 chunks for WIDTH = 246. Chunk 0 is `y[31:0]`.
  - MISR update: `sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ f`. `sig_a` and `sig_b` are updated independently.
  - Compare: if `y_a != y_b` (full WIDTH, not the fold):
    - `mism_count` increments, saturating at 255;
    - if `mismatch` was 0, then `first_idx <= samp_idx` and `mismatch <= 1`.
  - `samp_idx` increments. When the accepted sample is number NSAMP (`samp_idx` = NSAMP-1 before the edge), go to DONE.
- RUN with `valid` = 0: no state changes. Gaps are allowed and have unbounded length.
- DONE: all outputs hold and `valid` is ignored. `start` = 1 begins a new run exactly as from IDLE.
- Width rules:
  - fold and MISR arithmetic is unsigned XOR/shift only;
  - counters are 8-bit unsigned;
  - NSAMP > 255 is illegal; the implementation asserts on it in simulation.

## Timing
- All outputs are registered. Sample effects are visible on the cycle after the accepting edge.
- Latency from `start` to `busy` = 1 is 1 cycle. The first sample can be accepted on the edge after the one that captured `start`.
- `done` rises on the same edge that absorbs the final sample, so the final signatures and counts are valid when `done` = 1.
- `start` and `valid` high on the same edge in IDLE or DONE: only `start` acts, and the sample is dropped.
- A `rst` during RUN aborts the run. Outputs read 0 on the next cycle, and no partial result is retained.
- Throughput is one sample per cycle, with `valid` high continuously.

## Test plan
- Reset check: assert `rst` for 2 cycles with random inputs. Afterwards every output = 0 and the FSM is in IDLE; `busy` = 0 and `done` = 0.
- Single zero sample (NSAMP = 1): `start`, then `valid` with `y_a` = `y_b` = 0. Required result:
  - `sig_a` = `sig_b` = 32'hFB3EE249;
  - `done` = 1 and `mismatch` = 0;
  - `samp_idx` = 1.
- Identical streams (NSAMP = 22): apply 22 random equal samples with `valid` high. Required result:
  - `done` one cycle after the 22nd accepting edge;
  - `sig_a` == `sig_b` and matches the model;
  - `mism_count` = 0.
- Injected divergence: flip bit 245 of `y_a` at sample indices 5 and 9. Required result:
  - `mismatch` = 1, `first_idx` = 5, `mism_count` = 2;
  - `sig_a` != `sig_b`.
- Gaps and collisions:
  - insert 3-cycle `valid` gaps between samples: the signatures equal the no-gap run;
  - pulse `start` while in RUN: ignored;
  - drive `start` with `valid` in DONE: the sample is dropped and `samp_idx` = 0.
- Reset mid-run: assert `rst` after 10 samples. Required result:
  - all outputs are 0 next cycle;
  - a new `start` plus 22 samples produces the same result as a clean run.

Source files
------------

// File: rtl/y_diff_checker.sv
// y_diff_checker
//
// Compares two copies of a wide output bus sample by sample. y_a comes from
// the synthesized netlist and y_b from the behavioural reference. Each
// stream is folded to 32 bits and compressed into its own MISR signature.
// The block also counts mismatching samples and records the index of the
// first divergence. One run is NSAMP accepted samples, and the result is
// held in DONE until the next start.
//
// Handshake: valid is a one-sided strobe and there is no ready. A sample is
// accepted on every rising edge in RUN where valid = 1, so throughput is one
// sample per cycle. valid = 0 cycles are gaps of any length and change
// nothing. Outside RUN, valid is ignored. When start and valid are both
// high in IDLE or DONE, only start acts and the sample is dropped.

module y_diff_checker #(
    parameter int          WIDTH = 246,
    parameter int          NSAMP = 22,
    parameter logic [31:0] POLY  = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] y_a,
    input  logic [WIDTH-1:0] y_b,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       mism_count,
    output logic [7:0]       first_idx,
    output logic [7:0]       samp_idx,
    output logic [31:0]      sig_a,
    output logic [31:0]      sig_b,
    output logic [1:0]       state_dbg
);

    // Number of 32-bit chunks after zero-extending y to a multiple of 32.
    localparam int NCHUNK = (WIDTH + 31) / 32;

    // samp_idx value before the edge that accepts the final sample of a run.
    localparam logic [7:0] LAST_IDX = 8'(NSAMP - 1);

    // Seed loaded into both signatures at the start of every run.
    localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;

    // XOR of all 32-bit chunks of the zero-extended bus. Chunk 0 is y[31:0].
    function automatic logic [31:0] fold(input logic [WIDTH-1:0] y);
        logic [NCHUNK*32-1:0] ext;
        logic [31:0]          f;
        ext            = '0;
        ext[WIDTH-1:0] = y;
        f              = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            f = f ^ ext[i*32 +: 32];
        end
        return f;
    endfunction

    // One MISR step: shift left, apply the feedback polynomial when the
    // outgoing bit is set, then XOR in the folded sample.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [31:0] f);
        logic [31:0] n;
        n = {sig[30:0], 1'b0};
        if (sig[31]) begin
            n = n ^ POLY;
        end
        return n ^ f;
    endfunction

    logic [31:0] fold_a;
    logic [31:0] fold_b;
    logic [31:0] sig_a_next;
    logic [31:0] sig_b_next;
    logic        differ;
    logic        is_last;
    logic [7:0]  mism_count_inc;
    logic [7:0]  samp_idx_inc;

    // Next-sample datapath: folds, MISR steps, the full-width compare and
    // the saturating mismatch counter.
    always_comb begin
        fold_a         = fold(y_a);
        fold_b         = fold(y_b);
        sig_a_next     = misr_step(sig_a, fold_a);
        sig_b_next     = misr_step(sig_b, fold_b);
        differ         = (y_a != y_b);
        is_last        = (samp_idx == LAST_IDX);
        samp_idx_inc   = samp_idx + 8'd1;
        mism_count_inc = (mism_count == 8'hFF) ? 8'hFF : (mism_count + 8'd1);
    end

    // Run FSM with registered status, signatures and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mismatch   <= 1'b0;
            mism_count <= 8'd0;
            first_idx  <= 8'd0;
            samp_idx   <= 8'd0;
            sig_a      <= 32'd0;
            sig_b      <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // A start beginning a run takes priority over any valid
                    // on the same edge, so that sample is dropped.
                    if (start) begin
                        state      <= S_RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        mismatch   <= 1'b0;
                        mism_count <= 8'd0;
                        first_idx  <= 8'd0;
                        samp_idx   <= 8'd0;
                        sig_a      <= SIG_SEED;
                        sig_b      <= SIG_SEED;
                    end
                end

                S_RUN: begin
                    // start is ignored in RUN. Only an accepted sample
                    // advances anything.
                    if (valid) begin
                        sig_a    <= sig_a_next;
                        sig_b    <= sig_b_next;
                        samp_idx <= samp_idx_inc;
                        if (differ) begin
                            mism_count <= mism_count_inc;
                            if (!mismatch) begin
                                first_idx <= samp_idx;
                                mismatch  <= 1'b1;
                            end
                        end
                        // done rises on the edge that absorbs the last
                        // sample, so the results are complete when done = 1.
                        if (is_last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

    // A run length outside 1..255 cannot be tracked by the 8-bit counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (NSAMP >= 1 && NSAMP <= 255);
        end
    end

endmodule

// File: tb/tb_y_diff_checker.sv
// Directed bench for y_diff_checker. The main instance runs with NSAMP = 22.
// A second instance with NSAMP = 1 covers the single-sample case.
// Expected signatures come from a bit-serial fold and MISR model.

module tb_y_diff_checker;

    localparam int          W    = 246;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         valid;
    logic         start1;
    logic         valid1;
    logic [W-1:0] y_a;
    logic [W-1:0] y_b;

    logic         busy, done, mismatch;
    logic [7:0]   mism_count, first_idx, samp_idx;
    logic [31:0]  sig_a, sig_b;
    logic [1:0]   state_dbg;

    logic         busy1, done1, mismatch1;
    logic [7:0]   mism_count1, first_idx1, samp_idx1;
    logic [31:0]  sig_a1, sig_b1;
    logic [1:0]   state_dbg1;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] samp [22];
    logic [31:0]  ref_a, ref_b, clean_sig;
    logic [W-1:0] tmp;

    always #5 clk = ~clk;

    y_diff_checker #(.WIDTH(W), .NSAMP(22), .POLY(POLY)) dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid),
        .y_a(y_a), .y_b(y_b),
        .busy(busy), .done(done), .mismatch(mismatch),
        .mism_count(mism_count), .first_idx(first_idx), .samp_idx(samp_idx),
        .sig_a(sig_a), .sig_b(sig_b), .state_dbg(state_dbg)
    );

    y_diff_checker #(.WIDTH(W), .NSAMP(1), .POLY(POLY)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .valid(valid1),
        .y_a(y_a), .y_b(y_b),
        .busy(busy1), .done(done1), .mismatch(mismatch1),
        .mism_count(mism_count1), .first_idx(first_idx1), .samp_idx(samp_idx1),
        .sig_a(sig_a1), .sig_b(sig_b1), .state_dbg(state_dbg1)
    );

    // Bit-serial fold: bit i of y lands in bit (i mod 32) of the fold.
    function automatic logic [31:0] m_fold(input logic [W-1:0] y);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < W; i++) begin
            f[i % 32] = f[i % 32] ^ y[i];
        end
        return f;
    endfunction

    function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] n;
        n = s << 1;
        if (s[31]) n = n ^ POLY;
        return n ^ f;
    endfunction

    function automatic logic [W-1:0] rand_y();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r[W-1:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, ".busy"},       32'(busy),       32'd0);
        chk({pfx, ".done"},       32'(done),       32'd0);
        chk({pfx, ".mismatch"},   32'(mismatch),   32'd0);
        chk({pfx, ".mism_count"}, 32'(mism_count), 32'd0);
        chk({pfx, ".first_idx"},  32'(first_idx),  32'd0);
        chk({pfx, ".samp_idx"},   32'(samp_idx),   32'd0);
        chk({pfx, ".sig_a"},      sig_a,           32'd0);
        chk({pfx, ".sig_b"},      sig_b,           32'd0);
        chk({pfx, ".state"},      32'(state_dbg),  32'd0);
        chk({pfx, ".dut1_busy"},  32'(busy1),      32'd0);
        chk({pfx, ".dut1_done"},  32'(done1),      32'd0);
        chk({pfx, ".dut1_sig_a"}, sig_a1,          32'd0);
    endtask

    // One accepted-sample cycle on the main instance.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic st);
        start = st;
        valid = 1'b1;
        y_a   = a;
        y_b   = b;
        tick();
        start = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        valid  = 1'b0;
        start1 = 1'b0;
        valid1 = 1'b0;
        y_a    = '0;
        y_b    = '0;
        tick();

        // Reset for 2 cycles with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start  = 1'($urandom_range(0, 1));
            valid  = 1'($urandom_range(0, 1));
            start1 = 1'($urandom_range(0, 1));
            valid1 = 1'($urandom_range(0, 1));
            y_a    = rand_y();
            y_b    = rand_y();
            tick();
        end
        rst    = 1'b0;
        start  = 1'b0;
        valid  = 1'b0;
        start1 = 1'b0;
        valid1 = 1'b0;
        chk_zero("reset");

        // Single zero sample on the NSAMP = 1 instance.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("one.busy", 32'(busy1), 32'd1);
        valid1 = 1'b1;
        y_a    = '0;
        y_b    = '0;
        tick();
        valid1 = 1'b0;
        chk("one.sig_a",    sig_a1,           32'hFB3EE249);
        chk("one.sig_b",    sig_b1,           32'hFB3EE249);
        chk("one.done",     32'(done1),       32'd1);
        chk("one.busy_off", 32'(busy1),       32'd0);
        chk("one.mismatch", 32'(mismatch1),   32'd0);
        chk("one.samp_idx", 32'(samp_idx1),   32'd1);

        // Identical streams of 22 random samples, valid held high.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("same.busy",  32'(busy),     32'd1);
        chk("same.seed",  sig_a,         32'hFFFFFFFF);
        chk("same.state", 32'(state_dbg), 32'd1);
        ref_a = 32'hFFFFFFFF;
        for (int i = 0; i < 22; i++) begin
            samp[i] = rand_y();
            ref_a   = m_misr(ref_a, m_fold(samp[i]));
            send(samp[i], samp[i], 1'b0);
            if (i == 20) chk("same.done_early", 32'(done), 32'd0);
        end
        clean_sig = ref_a;
        chk("same.done",       32'(done),       32'd1);
        chk("same.busy_off",   32'(busy),       32'd0);
        chk("same.sig_a",      sig_a,           clean_sig);
        chk("same.sig_b",      sig_b,           clean_sig);
        chk("same.mism_count", 32'(mism_count), 32'd0);
        chk("same.mismatch",   32'(mismatch),   32'd0);
        chk("same.samp_idx",   32'(samp_idx),   32'd22);

        // Bit 245 of y_a flipped at samples 5 and 9, plus a start pulse mid-run.
        start = 1'b1;
        tick();
        start = 1'b0;
        ref_a = 32'hFFFFFFFF;
        for (int i = 0; i < 22; i++) begin
            tmp = samp[i];
            if (i == 5 || i == 9) tmp[245] = ~tmp[245];
            ref_a = m_misr(ref_a, m_fold(tmp));
            send(tmp, samp[i], (i == 3));
            if (i == 3) chk("div.start_ignored", 32'(samp_idx), 32'd4);
            if (i == 6) begin
                chk("div.first_idx_early", 32'(first_idx),  32'd5);
                chk("div.count_early",     32'(mism_count), 32'd1);
            end
        end
        chk("div.mismatch",   32'(mismatch),   32'd1);
        chk("div.first_idx",  32'(first_idx),  32'd5);
        chk("div.mism_count", 32'(mism_count), 32'd2);
        chk("div.sig_a",      sig_a,           ref_a);
        chk("div.sig_b",      sig_b,           clean_sig);
        n_vec++;
        assert (sig_a !== sig_b) else begin
            n_err++;
            $error("FAIL div.sig_differ: observed %h equal to %h, expected different", sig_a, sig_b);
        end

        // Same stream with 3-cycle valid gaps of garbage data.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 22; i++) begin
            send(samp[i], samp[i], 1'b0);
            if (i < 21) begin
                for (int g = 0; g < 3; g++) begin
                    y_a = rand_y();
                    y_b = rand_y();
                    tick();
                end
            end
            if (i == 0) begin
                chk("gap.samp_idx", 32'(samp_idx), 32'd1);
                chk("gap.sig_a0",   sig_a,         m_misr(32'hFFFFFFFF, m_fold(samp[0])));
            end
        end
        chk("gap.sig_a",    sig_a,         clean_sig);
        chk("gap.sig_b",    sig_b,         clean_sig);
        chk("gap.done",     32'(done),     32'd1);
        chk("gap.mismatch", 32'(mismatch), 32'd0);

        // start with valid in DONE: the sample is dropped.
        tmp = rand_y();
        send(tmp, ~tmp, 1'b1);
        chk("coll.samp_idx",   32'(samp_idx),   32'd0);
        chk("coll.busy",       32'(busy),       32'd1);
        chk("coll.done",       32'(done),       32'd0);
        chk("coll.mism_count", 32'(mism_count), 32'd0);
        chk("coll.mismatch",   32'(mismatch),   32'd0);
        chk("coll.sig_a",      sig_a,           32'hFFFFFFFF);
        chk("coll.sig_b",      sig_b,           32'hFFFFFFFF);

        // Reset after 10 samples, then a clean run.
        for (int i = 0; i < 10; i++) begin
            send(samp[i], ~samp[i], 1'b0);
        end
        chk("mid.samp_idx", 32'(samp_idx), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 22; i++) begin
            send(samp[i], samp[i], 1'b0);
        end
        chk("rerun.sig_a",      sig_a,           clean_sig);
        chk("rerun.sig_b",      sig_b,           clean_sig);
        chk("rerun.done",       32'(done),       32'd1);
        chk("rerun.mism_count", 32'(mism_count), 32'd0);
        chk("rerun.samp_idx",   32'(samp_idx),   32'd22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
